data_cache_ctrl: RTL and testbench

Parametrised N-way write-back data cache controller. It generalises the single-shot miss FSM with per-beat burst counting for refill and write-back, a full-cache flush walk, and bus-error capture. It sits between the data cache arrays (tag, valid, dirty, LRU, data) and the memory-side burst read/write engines, and drives the stall seen by the core.

---
 rtl/dcache_pkg.sv | 27 ++
 rtl/dcache_wrap_counter.sv | 36 +++
 rtl/data_cache_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_data_cache_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_pkg
//  Purpose  : Shared state encoding and index-width helper for the data
//             cache controller and its counters.
//  Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   // Controller states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_COMPARE_TAG = 3'd1,
      ST_WRITE_BACK  = 3'd2,
      ST_ALLOCATE    = 3'd3,
      ST_FLUSH_CHECK = 3'd4,
      ST_FLUSH_WB    = 3'd5,
      ST_ERROR       = 3'd6
   } t_dc_state;

   // Index width for a power-of-two count; never below one bit
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_wrap_counter
//  Purpose  : Up-counter with synchronous clear that wraps to zero after a
//             programmable maximum. o_wrap flags the enabled cycle at max.
//  Revision : 1.0 - initial release
// ============================================================================
module dcache_wrap_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_max,
   output logic [WIDTH-1:0] o_count,
   output logic             o_wrap
);

   logic [WIDTH-1:0] r_count;

   assign o_wrap  = i_en && (r_count == i_max);
   assign o_count = r_count;

   // Count on enable, return to zero after max; clear has priority
   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         r_count <= '0;
      else if (i_clr)
         r_count <= '0;
      else if (i_en)
         r_count <= o_wrap ? '0 : r_count + 1'b1;
   end

endmodule : dcache_wrap_counter
`default_nettype wire

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache_ctrl
//  Purpose  : N-way write-back data cache controller. Sequences tag compare,
//             victim write-back, burst refill, full-cache flush walk and
//             bus-error capture; drives the core stall.
//  Revision : 1.0 - initial release
// ============================================================================
module data_cache_ctrl
   import dcache_pkg::*;
#(
   parameter int unsigned N_WAYS      = 4,
   parameter int unsigned N_SETS      = 16,
   parameter int unsigned BLOCK_WORDS = 16
) (
   input  logic                             clk,
   input  logic                             arst,
   input  logic                             i_start_check,
   input  logic                             i_flush,
   input  logic                             i_hit,
   input  logic                             i_dirty,
   input  logic                             i_r_valid,
   input  logic                             i_r_last,
   input  logic                             i_r_err,
   input  logic                             i_w_ready,
   input  logic                             i_b_valid,
   input  logic                             i_b_err,
   input  logic                             i_err_clear,
   output logic                             o_stall,
   output logic                             o_word_write_en,
   output logic [idx_width(BLOCK_WORDS)-1:0] o_beat,
   output logic                             o_w_last,
   output logic                             o_valid_update,
   output logic                             o_dirty_clear,
   output logic                             o_lru_update,
   output logic                             o_start_read,
   output logic                             o_start_write,
   output logic                             o_addr_control,
   output logic [idx_width(N_SETS)-1:0]      o_flush_set,
   output logic [idx_width(N_WAYS)-1:0]      o_flush_way,
   output logic                             o_flush_done,
   output logic                             o_bus_error
);

   localparam int unsigned c_beat_w = idx_width(BLOCK_WORDS);
   localparam int unsigned c_set_w  = idx_width(N_SETS);
   localparam int unsigned c_way_w  = idx_width(N_WAYS);

   localparam logic [c_beat_w-1:0] c_beat_max = c_beat_w'(BLOCK_WORDS - 1);
   localparam logic [c_set_w-1:0]  c_set_max  = c_set_w'(N_SETS - 1);
   localparam logic [c_way_w-1:0]  c_way_max  = c_way_w'(N_WAYS - 1);

   t_dc_state           r_state;
   logic                r_flush_done;

   logic [c_beat_w-1:0] w_beat;
   logic                w_beat_wrap;
   logic                w_beat_en;
   logic                w_beat_clr;
   logic [c_set_w-1:0]  w_set;
   logic                w_set_wrap;
   logic [c_way_w-1:0]  w_way;
   logic                w_way_wrap;

   logic                w_wb_state;
   logic                w_alloc;
   logic                w_wb_resp_ok;
   logic                w_wb_resp_err;
   logic                w_r_err;
   logic                w_refill_done;
   logic                w_to_error;
   logic                w_flush_step;

   // Shared event decode used by both the counters and the state register
   always_comb begin
      w_wb_state    = (r_state == ST_WRITE_BACK) || (r_state == ST_FLUSH_WB);
      w_alloc       = (r_state == ST_ALLOCATE);
      w_beat_en     = (w_wb_state && i_w_ready) || (w_alloc && i_r_valid);
      w_wb_resp_ok  = w_wb_state && i_b_valid && !i_b_err;
      w_wb_resp_err = w_wb_state && i_b_valid && i_b_err;
      // A last beat anywhere but the final word is treated as a protocol error
      w_r_err       = w_alloc && i_r_valid && (i_r_err || (i_r_last && !w_beat_wrap));
      w_refill_done = w_alloc && i_r_valid && i_r_last && w_beat_wrap && !i_r_err;
      w_to_error    = w_r_err || w_wb_resp_err;
      // Beat from a write-back is counted first; the response then zeroes it
      w_beat_clr    = w_to_error || w_wb_resp_ok;
      w_flush_step  = ((r_state == ST_FLUSH_CHECK) && !i_dirty) ||
                      ((r_state == ST_FLUSH_WB) && w_wb_resp_ok);
   end

   dcache_wrap_counter #(.WIDTH(c_beat_w)) u_beat_cnt (
      .clk     (clk),
      .arst    (arst),
      .i_en    (w_beat_en),
      .i_clr   (w_beat_clr),
      .i_max   (c_beat_max),
      .o_count (w_beat),
      .o_wrap  (w_beat_wrap)
   );

   // Flush walk: way is the inner index, set the outer
   dcache_wrap_counter #(.WIDTH(c_way_w)) u_way_cnt (
      .clk     (clk),
      .arst    (arst),
      .i_en    (w_flush_step),
      .i_clr   (w_to_error),
      .i_max   (c_way_max),
      .o_count (w_way),
      .o_wrap  (w_way_wrap)
   );

   dcache_wrap_counter #(.WIDTH(c_set_w)) u_set_cnt (
      .clk     (clk),
      .arst    (arst),
      .i_en    (w_flush_step && w_way_wrap),
      .i_clr   (w_to_error),
      .i_max   (c_set_max),
      .o_count (w_set),
      .o_wrap  (w_set_wrap)
   );

   // Controller state register and flush-complete pulse
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state      <= ST_IDLE;
         r_flush_done <= 1'b0;
      end else begin
         // w_set_wrap only fires on the step past the last line of the walk
         r_flush_done <= w_set_wrap;
         case (r_state)
            ST_IDLE: begin
               if (i_flush)
                  r_state <= ST_FLUSH_CHECK;
               else if (i_start_check)
                  r_state <= ST_COMPARE_TAG;
            end
            ST_COMPARE_TAG: begin
               if (i_hit)
                  r_state <= ST_IDLE;
               else if (i_dirty)
                  r_state <= ST_WRITE_BACK;
               else
                  r_state <= ST_ALLOCATE;
            end
            ST_WRITE_BACK: begin
               if (w_wb_resp_err)
                  r_state <= ST_ERROR;
               else if (w_wb_resp_ok)
                  r_state <= ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
               if (w_r_err)
                  r_state <= ST_ERROR;
               else if (w_refill_done)
                  r_state <= ST_COMPARE_TAG;
            end
            ST_FLUSH_CHECK: begin
               if (i_dirty)
                  r_state <= ST_FLUSH_WB;
               else if (w_set_wrap)
                  r_state <= ST_IDLE;
            end
            ST_FLUSH_WB: begin
               if (w_wb_resp_err)
                  r_state <= ST_ERROR;
               else if (w_wb_resp_ok)
                  r_state <= w_set_wrap ? ST_IDLE : ST_FLUSH_CHECK;
            end
            ST_ERROR: begin
               if (i_err_clear)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Output decode from registered state, counters and live inputs
   always_comb begin
      o_stall         = !((r_state == ST_COMPARE_TAG) && i_hit);
      o_lru_update    = (r_state == ST_COMPARE_TAG) && i_hit;
      o_word_write_en = w_alloc && i_r_valid;
      o_start_read    = w_alloc;
      o_start_write   = w_wb_state;
      o_w_last        = w_wb_state && (w_beat == c_beat_max);
      o_dirty_clear   = w_wb_resp_ok;
      o_valid_update  = w_refill_done;
      o_addr_control  = !((r_state == ST_FLUSH_CHECK) || w_wb_state ||
                          ((r_state == ST_COMPARE_TAG) && !i_hit && i_dirty));
      o_bus_error     = (r_state == ST_ERROR);
      o_flush_done    = r_flush_done;
      o_beat          = w_beat;
      o_flush_set     = w_set;
      o_flush_way     = w_way;
   end

endmodule : data_cache_ctrl
`default_nettype wire

// File: tb/tb_data_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_cache_ctrl
//  Purpose  : Directed self-checking bench for data_cache_ctrl
//             (4 ways, 16 sets, 16-word lines).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_cache_ctrl;

   logic       clk = 1'b0;
   logic       arst;
   logic       start_check, flush, hit, dirty;
   logic       r_valid, r_last, r_err, w_ready, b_valid, b_err, err_clear;
   logic       stall, word_write_en, w_last, valid_update, dirty_clear, lru_update;
   logic       start_read, start_write, addr_control, flush_done, bus_error;
   logic [3:0] beat;
   logic [3:0] flush_set;
   logic [1:0] flush_way;

   int n_checks = 0;
   int n_fail   = 0;

   data_cache_ctrl #(.N_WAYS(4), .N_SETS(16), .BLOCK_WORDS(16)) dut (
      .clk             (clk),
      .arst            (arst),
      .i_start_check   (start_check),
      .i_flush         (flush),
      .i_hit           (hit),
      .i_dirty         (dirty),
      .i_r_valid       (r_valid),
      .i_r_last        (r_last),
      .i_r_err         (r_err),
      .i_w_ready       (w_ready),
      .i_b_valid       (b_valid),
      .i_b_err         (b_err),
      .i_err_clear     (err_clear),
      .o_stall         (stall),
      .o_word_write_en (word_write_en),
      .o_beat          (beat),
      .o_w_last        (w_last),
      .o_valid_update  (valid_update),
      .o_dirty_clear   (dirty_clear),
      .o_lru_update    (lru_update),
      .o_start_read    (start_read),
      .o_start_write   (start_write),
      .o_addr_control  (addr_control),
      .o_flush_set     (flush_set),
      .o_flush_way     (flush_way),
      .o_flush_done    (flush_done),
      .o_bus_error     (bus_error)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clr_inputs();
      start_check = 0; flush = 0; hit = 0; dirty = 0;
      r_valid = 0; r_last = 0; r_err = 0; w_ready = 0;
      b_valid = 0; b_err = 0; err_clear = 0;
   endtask

   // Advance one clock; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bring the controller from IDLE into ALLOCATE via a clean miss
   task automatic enter_allocate();
      start_check = 1; tick(); start_check = 0;
      hit = 0; dirty = 0; tick();
   endtask

   task automatic test_reset();
      clr_inputs();
      arst = 1;
      #3;
      n_checks++;
      if (stall !== 1 || addr_control !== 1 || word_write_en !== 0 || w_last !== 0 ||
          valid_update !== 0 || dirty_clear !== 0 || lru_update !== 0 || start_read !== 0 ||
          start_write !== 0 || flush_done !== 0 || bus_error !== 0 || beat !== 0 ||
          flush_set !== 0 || flush_way !== 0) begin
         n_fail++;
         $display("FAIL reset_outputs: stall=%b addr=%b beat=%0d start_r=%b start_w=%b err=%b set=%0d way=%0d, required stall=1 addr=1 others 0",
                  stall, addr_control, beat, start_read, start_write, bus_error, flush_set, flush_way);
      end
      tick();
      arst = 0;
      tick();
   endtask

   task automatic test_hit();
      hit = 1; #1;
      n_checks++;
      if (stall !== 1 || lru_update !== 0) begin
         n_fail++;
         $display("FAIL idle_ignores_hit: stall=%b lru=%b, required 1 0", stall, lru_update);
      end
      hit = 0; start_check = 1; tick(); start_check = 0;
      hit = 1; #1;
      n_checks++;
      if (stall !== 0 || lru_update !== 1 || addr_control !== 1) begin
         n_fail++;
         $display("FAIL hit_compare: stall=%b lru=%b addr=%b, required 0 1 1", stall, lru_update, addr_control);
      end
      tick(); #1;
      n_checks++;
      if (stall !== 1 || lru_update !== 0) begin
         n_fail++;
         $display("FAIL hit_back_to_idle: stall=%b lru=%b, required 1 0", stall, lru_update);
      end
      hit = 0;
   endtask

   task automatic test_clean_miss();
      int pulses = 0;
      start_check = 1; tick(); start_check = 0;
      hit = 0; dirty = 0; #1;
      n_checks++;
      if (stall !== 1 || addr_control !== 1 || start_read !== 0 || start_write !== 0) begin
         n_fail++;
         $display("FAIL clean_miss_compare: stall=%b addr=%b start_r=%b start_w=%b, required 1 1 0 0",
                  stall, addr_control, start_read, start_write);
      end
      tick();
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 1) begin
            r_valid = 0; #1;
            n_checks++;
            if (start_read !== 1 || word_write_en !== 0 || beat !== 4'(i)) begin
               n_fail++;
               $display("FAIL refill_gap_%0d: start_r=%b we=%b beat=%0d, required 1 0 %0d",
                        i, start_read, word_write_en, beat, i);
            end
            tick();
         end
         r_valid = 1; r_last = (i == 15); #1;
         if (word_write_en === 1) pulses++;
         n_checks++;
         if (start_read !== 1 || word_write_en !== 1 || beat !== 4'(i) ||
             valid_update !== (i == 15) || stall !== 1) begin
            n_fail++;
            $display("FAIL refill_beat_%0d: start_r=%b we=%b beat=%0d vu=%b stall=%b, required 1 1 %0d %b 1",
                     i, start_read, word_write_en, beat, valid_update, stall, i, (i == 15));
         end
         tick();
      end
      r_valid = 0; r_last = 0;
      n_checks++;
      if (pulses != 16) begin
         n_fail++;
         $display("FAIL refill_pulse_count: got %0d, required 16", pulses);
      end
      hit = 1; #1;
      n_checks++;
      if (stall !== 0 || lru_update !== 1 || start_read !== 0 || beat !== 0) begin
         n_fail++;
         $display("FAIL refill_then_hit: stall=%b lru=%b start_r=%b beat=%0d, required 0 1 0 0",
                  stall, lru_update, start_read, beat);
      end
      tick(); hit = 0;
   endtask

   // Dirty miss; when same_cycle is set the final beat and response coincide
   task automatic dirty_miss(input bit same_cycle, input string tag);
      start_check = 1; tick(); start_check = 0;
      hit = 0; dirty = 1; #1;
      n_checks++;
      if (addr_control !== 0 || stall !== 1) begin
         n_fail++;
         $display("FAIL %s_compare: addr=%b stall=%b, required 0 1", tag, addr_control, stall);
      end
      tick(); dirty = 0;
      for (int i = 0; i < 16; i++) begin
         w_ready = 1;
         b_valid = same_cycle && (i == 15);
         #1;
         n_checks++;
         if (start_write !== 1 || addr_control !== 0 || beat !== 4'(i) || w_last !== (i == 15) ||
             dirty_clear !== (same_cycle && i == 15) || start_read !== 0) begin
            n_fail++;
            $display("FAIL %s_wb_beat_%0d: start_w=%b addr=%b beat=%0d wlast=%b dclr=%b, required 1 0 %0d %b %b",
                     tag, i, start_write, addr_control, beat, w_last, dirty_clear, i, (i == 15),
                     (same_cycle && i == 15));
         end
         tick();
      end
      w_ready = 0;
      if (!same_cycle) begin
         b_valid = 1; #1;
         n_checks++;
         if (dirty_clear !== 1 || start_write !== 1 || beat !== 0) begin
            n_fail++;
            $display("FAIL %s_b_resp: dclr=%b start_w=%b beat=%0d, required 1 1 0", tag, dirty_clear, start_write, beat);
         end
         tick();
      end
      b_valid = 0; #1;
      n_checks++;
      if (start_read !== 1 || start_write !== 0 || beat !== 0 || addr_control !== 1) begin
         n_fail++;
         $display("FAIL %s_to_allocate: start_r=%b start_w=%b beat=%0d addr=%b, required 1 0 0 1",
                  tag, start_read, start_write, beat, addr_control);
      end
      for (int i = 0; i < 16; i++) begin
         r_valid = 1; r_last = (i == 15); tick();
      end
      r_valid = 0; r_last = 0;
      hit = 1; #1;
      n_checks++;
      if (stall !== 0 || lru_update !== 1) begin
         n_fail++;
         $display("FAIL %s_final_hit: stall=%b lru=%b, required 0 1", tag, stall, lru_update);
      end
      tick(); hit = 0;
   endtask

   task automatic test_dirty_miss();
      dirty_miss(1'b0, "dirty_miss");
   endtask

   task automatic test_back_to_back();
      dirty_miss(1'b1, "b2b");
   endtask

   task automatic test_flush();
      int wbs = 0;
      flush = 1; tick(); flush = 0;
      for (int s = 0; s < 16; s++) begin
         for (int w = 0; w < 4; w++) begin
            dirty = ((s == 3) && (w == 1)) || ((s == 15) && (w == 3));
            #1;
            n_checks++;
            if (flush_set !== 4'(s) || flush_way !== 2'(w) || addr_control !== 0 ||
                start_write !== 0 || flush_done !== 0 || stall !== 1) begin
               n_fail++;
               $display("FAIL flush_check_s%0d_w%0d: set=%0d way=%0d addr=%b start_w=%b done=%b, required %0d %0d 0 0 0",
                        s, w, flush_set, flush_way, addr_control, start_write, flush_done, s, w);
            end
            if (dirty) begin
               tick(); dirty = 0;
               for (int b = 0; b < 16; b++) begin
                  w_ready = 1; #1;
                  n_checks++;
                  if (start_write !== 1 || beat !== 4'(b) || flush_set !== 4'(s) || flush_way !== 2'(w)) begin
                     n_fail++;
                     $display("FAIL flush_wb_s%0d_w%0d_b%0d: start_w=%b beat=%0d set=%0d way=%0d",
                              s, w, b, start_write, beat, flush_set, flush_way);
                  end
                  tick();
               end
               w_ready = 0; b_valid = 1; #1;
               if (dirty_clear === 1) wbs++;
               tick(); b_valid = 0;
            end else begin
               tick();
            end
            dirty = 0;
         end
      end
      #1;
      n_checks++;
      if (flush_done !== 1 || start_write !== 0 || addr_control !== 1 || flush_set !== 0 || flush_way !== 0) begin
         n_fail++;
         $display("FAIL flush_done_pulse: done=%b start_w=%b addr=%b set=%0d way=%0d, required 1 0 1 0 0",
                  flush_done, start_write, addr_control, flush_set, flush_way);
      end
      n_checks++;
      if (wbs != 2) begin
         n_fail++;
         $display("FAIL flush_writebacks: got %0d dirty clears, required 2", wbs);
      end
      tick(); #1;
      n_checks++;
      if (flush_done !== 0) begin
         n_fail++;
         $display("FAIL flush_done_single: done=%b, required 0", flush_done);
      end
   endtask

   task automatic test_errors();
      // Early last beat on a refill
      enter_allocate();
      for (int i = 0; i < 7; i++) begin
         r_valid = 1; tick();
      end
      r_last = 1; #1;
      n_checks++;
      if (valid_update !== 0 || beat !== 7) begin
         n_fail++;
         $display("FAIL early_last: vu=%b beat=%0d, required 0 7", valid_update, beat);
      end
      tick(); r_last = 0; #1;
      n_checks++;
      if (bus_error !== 1 || stall !== 1 || start_read !== 0 || word_write_en !== 0 || beat !== 0) begin
         n_fail++;
         $display("FAIL early_last_error: err=%b stall=%b start_r=%b we=%b beat=%0d, required 1 1 0 0 0",
                  bus_error, stall, start_read, word_write_en, beat);
      end
      tick(); r_valid = 0; #1;
      n_checks++;
      if (bus_error !== 1) begin
         n_fail++;
         $display("FAIL error_holds: err=%b, required 1", bus_error);
      end
      err_clear = 1; tick(); err_clear = 0; #1;
      n_checks++;
      if (bus_error !== 0 || stall !== 1 || addr_control !== 1) begin
         n_fail++;
         $display("FAIL error_clear: err=%b stall=%b addr=%b, required 0 1 1", bus_error, stall, addr_control);
      end
      // Write response error during a victim write-back
      start_check = 1; tick(); start_check = 0;
      dirty = 1; tick(); dirty = 0;
      for (int i = 0; i < 3; i++) begin
         w_ready = 1; tick();
      end
      w_ready = 0; b_valid = 1; b_err = 1; #1;
      n_checks++;
      if (dirty_clear !== 0 || start_write !== 1 || beat !== 3) begin
         n_fail++;
         $display("FAIL b_err_resp: dclr=%b start_w=%b beat=%0d, required 0 1 3", dirty_clear, start_write, beat);
      end
      tick(); b_valid = 0; b_err = 0; #1;
      n_checks++;
      if (bus_error !== 1 || start_write !== 0 || beat !== 0 || dirty_clear !== 0) begin
         n_fail++;
         $display("FAIL b_err_error: err=%b start_w=%b beat=%0d dclr=%b, required 1 0 0 0",
                  bus_error, start_write, beat, dirty_clear);
      end
      err_clear = 1; tick(); err_clear = 0;
   endtask

   task automatic test_arst_midburst();
      enter_allocate();
      for (int i = 0; i < 5; i++) begin
         r_valid = 1; tick();
      end
      #1;
      n_checks++;
      if (beat !== 5 || word_write_en !== 1) begin
         n_fail++;
         $display("FAIL arst_pre_beat: beat=%0d we=%b, required 5 1", beat, word_write_en);
      end
      arst = 1; #1;
      n_checks++;
      if (stall !== 1 || addr_control !== 1 || start_read !== 0 || word_write_en !== 0 ||
          beat !== 0 || bus_error !== 0 || start_write !== 0 || valid_update !== 0) begin
         n_fail++;
         $display("FAIL arst_midburst: stall=%b addr=%b start_r=%b we=%b beat=%0d err=%b, required 1 1 0 0 0 0",
                  stall, addr_control, start_read, word_write_en, beat, bus_error);
      end
      r_valid = 0;
      tick(); arst = 0; tick();
      start_check = 1; tick(); start_check = 0;
      hit = 1; #1;
      n_checks++;
      if (stall !== 0 || lru_update !== 1) begin
         n_fail++;
         $display("FAIL arst_recovery_hit: stall=%b lru=%b, required 0 1", stall, lru_update);
      end
      tick(); hit = 0;
   endtask

   initial begin
      test_reset();
      test_hit();
      test_clean_miss();
      test_dirty_miss();
      test_back_to_back();
      test_flush();
      test_errors();
      test_arst_midburst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_data_cache_ctrl
`default_nettype wire
